// File: rtl/pattern_sequencer.sv
// pattern_sequencer
// -----------------
// Per-channel pattern reader. On each request pulse from the channel
// controller it fetches the next record from a synchronous pattern ROM. It
// decodes note, rest, loop and end commands, then answers with a one-cycle
// o_valid. The note, duration and rest outputs hold their values until the
// next response.
//
// Handshake: i_enable is a one-cycle request that is accepted only while the
// block is not busy (IDLE or DONE). A request that arrives while o_busy=1 is
// dropped, not queued. Each accepted request produces exactly one o_valid
// pulse, unless an end command is reached or a restart abandons the fetch.
// o_note/o_duration/o_rest are already stable in the o_valid cycle.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_enable         request next note (one-cycle pulse)
//   i_restart        synchronous restart of the pattern at address 0
//   o_valid          one-cycle response pulse
//   o_note           note index (0 for rests), held
//   o_duration       note length in note strobes, held
//   o_rest           1 = silent note
//   o_done           end command reached; held until restart or reset
//   o_busy           fetch in progress (state not IDLE or DONE)
//   o_rom_rd         ROM read strobe
//   o_rom_addr       ROM address
//   i_rom_data       ROM word, valid the cycle after o_rom_rd
//   o_dbg_state      current FSM state, for checkers and debug
module pattern_sequencer #(
    parameter int ADDR_WIDTH     = 6,
    parameter int NOTE_WIDTH     = 6,
    parameter int DURATION_WIDTH = 6
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_enable,
    input  logic                                   i_restart,
    output logic                                   o_valid,
    output logic [NOTE_WIDTH-1:0]                  o_note,
    output logic [DURATION_WIDTH-1:0]              o_duration,
    output logic                                   o_rest,
    output logic                                   o_done,
    output logic                                   o_busy,
    output logic                                   o_rom_rd,
    output logic [ADDR_WIDTH-1:0]                  o_rom_addr,
    input  logic [2+NOTE_WIDTH+DURATION_WIDTH-1:0] i_rom_data,
    output logic [2:0]                             o_dbg_state
);

    localparam int WORD_WIDTH = 2 + NOTE_WIDTH + DURATION_WIDTH;

    localparam logic [1:0] CMD_NOTE = 2'b00;
    localparam logic [1:0] CMD_REST = 2'b01;
    localparam logic [1:0] CMD_LOOP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_DECODE  = 3'd2,
        S_RESPOND = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       ptr_q, ptr_d;
    logic                        loop_seen_q, loop_seen_d;
    logic                        valid_q, valid_d;
    logic [NOTE_WIDTH-1:0]       note_q, note_d;
    logic [DURATION_WIDTH-1:0]   dur_q, dur_d;
    logic                        rest_q, rest_d;
    logic                        done_q, done_d;

    // ROM word fields, MSB first: cmd, note, duration. A loop target reuses
    // the low address bits of the note+duration fields.
    logic [1:0]                  rom_cmd;
    logic [NOTE_WIDTH-1:0]       rom_note;
    logic [DURATION_WIDTH-1:0]   rom_dur;
    logic [ADDR_WIDTH-1:0]       rom_target;

    assign rom_cmd    = i_rom_data[WORD_WIDTH-1 -: 2];
    assign rom_note   = i_rom_data[NOTE_WIDTH+DURATION_WIDTH-1 -: NOTE_WIDTH];
    assign rom_dur    = i_rom_data[DURATION_WIDTH-1:0];
    assign rom_target = i_rom_data[ADDR_WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            loop_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            note_q      <= '0;
            dur_q       <= '0;
            rest_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            loop_seen_q <= loop_seen_d;
            valid_q     <= valid_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            rest_q      <= rest_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        loop_seen_d = loop_seen_q;
        valid_d     = 1'b0;
        note_d      = note_q;
        dur_d       = dur_q;
        rest_d      = rest_q;
        done_d      = done_q;

        if (i_restart) begin
            // Restart overrides whatever the FSM was doing. An in-flight
            // fetch is dropped, but the last response stays on the outputs.
            ptr_d       = '0;
            loop_seen_d = 1'b0;
            done_d      = 1'b0;
            state_d     = i_enable ? S_READ : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_enable) state_d = S_READ;
                end
                S_READ: begin
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    case (rom_cmd)
                        CMD_NOTE, CMD_REST: begin
                            rest_d      = (rom_cmd == CMD_REST);
                            note_d      = (rom_cmd == CMD_REST) ? '0 : rom_note;
                            dur_d       = rom_dur;
                            ptr_d       = ptr_q + 1'b1;
                            loop_seen_d = 1'b0;
                            valid_d     = 1'b1;
                            state_d     = S_RESPOND;
                        end
                        CMD_LOOP: begin
                            // Two loop words in a row would spin forever,
                            // so the second one ends the pattern.
                            if (!loop_seen_q) begin
                                ptr_d       = rom_target;
                                loop_seen_d = 1'b1;
                                state_d     = S_READ;
                            end else begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        default: begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
                S_RESPOND: begin
                    state_d = S_IDLE;
                end
                S_DONE: begin
                    // Keep answering with a maximal rest so the controller
                    // never waits forever on a finished pattern.
                    if (i_enable) begin
                        valid_d = 1'b1;
                        note_d  = '0;
                        rest_d  = 1'b1;
                        dur_d   = '1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign o_valid     = valid_q;
    assign o_note      = note_q;
    assign o_duration  = dur_q;
    assign o_rest      = rest_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q == S_READ) || (state_q == S_DECODE) ||
                         (state_q == S_RESPOND);
    assign o_rom_rd    = (state_q == S_READ);
    assign o_rom_addr  = ptr_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

    localparam int AW = 6;
    localparam int NW = 6;
    localparam int DW = 6;
    localparam int WW = 2 + NW + DW;
    localparam int WATCH = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_enable;
    logic          i_restart;
    logic          o_valid;
    logic [NW-1:0] o_note;
    logic [DW-1:0] o_duration;
    logic          o_rest;
    logic          o_done;
    logic          o_busy;
    logic          o_rom_rd;
    logic [AW-1:0] o_rom_addr;
    logic [WW-1:0] i_rom_data = '0;
    logic [2:0]    dbg_state;

    pattern_sequencer #(
        .ADDR_WIDTH    (AW),
        .NOTE_WIDTH    (NW),
        .DURATION_WIDTH(DW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_restart  (i_restart),
        .o_valid    (o_valid),
        .o_note     (o_note),
        .o_duration (o_duration),
        .o_rest     (o_rest),
        .o_done     (o_done),
        .o_busy     (o_busy),
        .o_rom_rd   (o_rom_rd),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / synchronous ROM ----------------
    always #5 i_clk = ~i_clk;

    logic [WW-1:0] rom [64];

    always @(posedge i_clk) begin
        if (o_rom_rd) i_rom_data <= rom[o_rom_addr];
    end

    function automatic logic [WW-1:0] word(input logic [1:0] cmd, input logic [5:0] note,
                                           input logic [5:0] dur);
        return {cmd, note, dur};
    endfunction

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Walks the ROM image directly: follows at most one loop per request,
    // and a second consecutive loop or an end word finishes the pattern.
    logic [5:0] m_ptr;
    bit         m_done;
    int         exp_q[$];
    int         exp_valid_at;
    logic [5:0] exp_note, exp_dur;
    logic       exp_rest;

    task automatic model_request();
        logic [5:0]    p;
        logic [WW-1:0] w;
        bit            seen;
        bit            fin;
        int            lat;
        exp_q.delete();
        exp_valid_at = -1;
        if (m_done) begin
            exp_valid_at = 1;
            exp_note     = 6'd0;
            exp_dur      = 6'd63;
            exp_rest     = 1'b1;
            return;
        end
        p    = m_ptr;
        seen = 0;
        fin  = 0;
        lat  = 1;
        while (!fin) begin
            exp_q.push_back(int'(p));
            w = rom[p];
            case (w[13:12])
                2'b00, 2'b01: begin
                    exp_valid_at = lat + 2;
                    exp_rest     = w[12];
                    exp_note     = w[12] ? 6'd0 : w[11:6];
                    exp_dur      = w[5:0];
                    m_ptr        = p + 6'd1;
                    fin          = 1;
                end
                2'b10: begin
                    if (!seen) begin
                        seen = 1;
                        p    = w[5:0];
                        lat += 2;
                    end else begin
                        m_done = 1;
                        fin    = 1;
                    end
                end
                default: begin
                    m_done = 1;
                    fin    = 1;
                end
            endcase
        end
    endtask

    // ---------------- driver / monitor ----------------
    int         obs_q[$];
    int         obs_valid_at;
    int         obs_nvalid;
    logic [5:0] obs_note, obs_dur;
    logic       obs_rest;

    // Pulses i_enable (optionally with i_restart) and watches a fixed window.
    // busy_at / restart_at inject one extra enable / restart pulse at that
    // window cycle (0 = none).
    task automatic watch(input bit with_restart, input int busy_at, input int restart_at);
        obs_q.delete();
        obs_valid_at = -1;
        obs_nvalid   = 0;
        i_enable     = 1'b1;
        i_restart    = with_restart;
        for (int t = 1; t <= WATCH; t++) begin
            @(posedge i_clk);
            #1;
            if (o_rom_rd) obs_q.push_back(int'(o_rom_addr));
            if (o_valid) begin
                obs_nvalid++;
                if (obs_valid_at < 0) begin
                    obs_valid_at = t;
                    obs_note     = o_note;
                    obs_dur      = o_duration;
                    obs_rest     = o_rest;
                end
            end
            i_enable  = (t == busy_at);
            i_restart = (t == restart_at);
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_nreads"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, "_read_addr"}, obs_q[i], exp_q[i]);
        check({tag, "_valid_at"}, obs_valid_at, exp_valid_at);
        check({tag, "_nvalid"}, obs_nvalid, (exp_valid_at > 0) ? 1 : 0);
        if (exp_valid_at > 0 && obs_nvalid > 0) begin
            check({tag, "_note"}, obs_note, exp_note);
            check({tag, "_dur"}, obs_dur, exp_dur);
            check({tag, "_rest"}, obs_rest, exp_rest);
        end
        check({tag, "_done"}, o_done, m_done);
        check({tag, "_busy_after"}, o_busy, 0);
    endtask

    // busy_at < 0 picks a random in-flight cycle for an ignored extra enable.
    task automatic request(input string tag, input bit with_restart, input int busy_at);
        int b;
        if (with_restart) begin
            m_ptr  = 6'd0;
            m_done = 0;
        end
        model_request();
        b = busy_at;
        if (b < 0) begin
            if (exp_q.size() > 0 && exp_valid_at > 0 && $urandom_range(0, 1) == 1)
                b = $urandom_range(1, exp_valid_at);
            else
                b = 0;
        end
        watch(with_restart, b, 0);
        compare(tag);
    endtask

    task automatic do_restart();
        i_restart = 1'b1;
        @(posedge i_clk);
        #1;
        i_restart = 1'b0;
        m_ptr     = 6'd0;
        m_done    = 0;
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [1:0] cmd;
        logic [5:0] note;
        logic [5:0] dur;
        bit         exp_valid;
        logic [5:0] exp_note;
        logic [5:0] exp_dur;
        bit         exp_rest;
        bit         exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        i_rst     = 1'b1;
        i_enable  = 1'b0;
        i_restart = 1'b0;
        m_ptr     = 6'd0;
        m_done    = 0;
        for (int i = 0; i < 64; i++) rom[i] = '0;

        vecs[0] = '{2'b00, 6'd12, 6'd4,  1'b1, 6'd12, 6'd4,  1'b0, 1'b0};
        vecs[1] = '{2'b01, 6'd33, 6'd2,  1'b1, 6'd0,  6'd2,  1'b1, 1'b0};
        vecs[2] = '{2'b00, 6'd63, 6'd63, 1'b1, 6'd63, 6'd63, 1'b0, 1'b0};
        vecs[3] = '{2'b01, 6'd5,  6'd0,  1'b1, 6'd0,  6'd0,  1'b1, 1'b0};
        vecs[4] = '{2'b11, 6'd0,  6'd0,  1'b0, 6'd0,  6'd0,  1'b0, 1'b1};
        vecs[5] = '{2'b10, 6'd0,  6'd0,  1'b0, 6'd0,  6'd0,  1'b0, 1'b1};

        // ---- reset state ----
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_note", o_note, 0);
        check("rst_dur", o_duration, 0);
        check("rst_rest", o_rest, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rom_rd", o_rom_rd, 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // ---- decode table on ROM[0] ----
        for (int i = 0; i < 6; i++) begin
            rom[0] = word(vecs[i].cmd, vecs[i].note, vecs[i].dur);
            do_restart();
            watch(0, 0, 0);
            check("tbl_nvalid", obs_nvalid, vecs[i].exp_valid ? 1 : 0);
            check("tbl_valid_at", obs_valid_at, vecs[i].exp_valid ? 3 : -1);
            if (vecs[i].exp_valid) begin
                check("tbl_note", obs_note, vecs[i].exp_note);
                check("tbl_dur", obs_dur, vecs[i].exp_dur);
                check("tbl_rest", obs_rest, vecs[i].exp_rest);
            end
            check("tbl_done", o_done, vecs[i].exp_done);
            check("tbl_first_read", (obs_q.size() > 0) ? obs_q[0] : -1, 0);
        end

        // ---- note, rest, taken loop ----
        rom[0] = word(2'b00, 6'd12, 6'd4);
        rom[1] = word(2'b01, 6'd17, 6'd2);
        rom[2] = word(2'b10, 6'd0, 6'd0);
        do_restart();
        request("seq_note", 0, 0);
        request("seq_rest", 0, 0);
        request("seq_loop", 0, 0);
        request("seq_after_loop", 0, 0);

        // ---- end, then DONE responses ----
        rom[0] = word(2'b11, 6'd0, 6'd0);
        do_restart();
        request("end_first", 0, 0);
        request("done_resp1", 0, 0);
        request("done_resp2", 0, 0);
        rom[0] = word(2'b00, 6'd20, 6'd9);
        request("done_restart_en", 1, 0);

        // ---- two consecutive loops ----
        rom[0] = word(2'b10, 6'd0, 6'd1);
        rom[1] = word(2'b10, 6'd0, 6'd0);
        do_restart();
        request("double_loop", 0, 0);

        // ---- restart during DECODE abandons the fetch ----
        rom[0] = word(2'b00, 6'd7, 6'd3);
        rom[1] = word(2'b00, 6'd9, 6'd5);
        do_restart();
        request("pre_abort", 0, 0);
        watch(0, 0, 2);
        check("abort_nvalid", obs_nvalid, 0);
        check("abort_reads", obs_q.size(), 1);
        check("abort_note_held", o_note, 7);
        check("abort_dur_held", o_duration, 3);
        m_ptr  = 6'd0;
        m_done = 0;
        request("after_abort", 0, 0);
        request("rst_en_idle", 1, 0);

        // ---- reset mid-fetch ----
        i_enable = 1'b1;
        @(posedge i_clk);
        #1;
        i_enable = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_rom_rd", o_rom_rd, 0);
        check("midrst_note", o_note, 0);
        @(posedge i_clk);
        #1;
        check("midrst_valid", o_valid, 0);
        i_rst = 1'b0;
        m_ptr  = 6'd0;
        m_done = 0;
        @(posedge i_clk);
        #1;
        request("after_midrst", 0, 0);

        // ---- address wrap with busy enables ----
        for (int i = 0; i < 64; i++)
            rom[i] = word(2'b00, 6'(i), 6'((i * 3) % 64));
        do_restart();
        for (int i = 0; i < 65; i++)
            request("wrap", 0, i % 4);

        // ---- randomized ----
        for (int i = 0; i < 64; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)      rom[i] = word(2'b00, 6'($urandom), 6'($urandom));
            else if (r < 80) rom[i] = word(2'b01, 6'($urandom), 6'($urandom));
            else if (r < 95) rom[i] = word(2'b10, 6'($urandom), 6'($urandom));
            else             rom[i] = word(2'b11, 6'($urandom), 6'($urandom));
        end
        do_restart();
        for (int i = 0; i < 300; i++) begin
            bit rs;
            rs = m_done ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
            request("rand", rs, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Responder side of the channel controller's pattern handshake. Each one-cycle o_pattern_enable pulse from the controller arrives here as i_enable. The block fetches the next record from a synchronous pattern ROM and decodes note, rest, loop and end commands. It returns a one-cycle o_valid with the note index and duration held stable for the pitch lookup and duration counter. One instance sits per channel, between channel_controller and the pattern ROM.

Parameters:
ADDR_WIDTH, 6, pattern ROM address width.
NOTE_WIDTH, 6, note index width; feeds the pitch lookup.
DURATION_WIDTH, 6, duration width; feeds the duration counter load value.

Ports:
i_clk  in  1  clock.
i_rst  in  1  reset, asynchronous, active-high.
i_enable  in  1  request next note; one-cycle pulse from channel controller.
i_restart  in  1  synchronous restart of the pattern at address 0.
o_valid  out  1  one-cycle pulse: o_note, o_duration and o_rest are updated.
o_note  out  NOTE_WIDTH  note index; held until the next o_valid.
o_duration  out  DURATION_WIDTH  note length in note strobes; held.
o_rest  out  1  1 = silent note; o_note is 0.
o_done  out  1  end command reached; held until restart or reset.
o_busy  out  1  fetch in progress (state not IDLE or DONE).
o_rom_rd  out  1  ROM read strobe.
o_rom_addr  out  ADDR_WIDTH  ROM address.
i_rom_data  in  2+NOTE_WIDTH+DURATION_WIDTH  ROM word; valid the cycle after o_rom_rd.

Behaviour:
- ROM word layout, MSB first: cmd[1:0], note field, duration field.
  - cmd 00 = note; 01 = rest; 10 = loop (target address = low ADDR_WIDTH bits of the note+duration fields); 11 = end.
- Reset (async): state IDLE; ptr=0; loop_seen=0; all outputs 0.
- States: IDLE, READ, DECODE, RESPOND, DONE.
- IDLE:
  - i_enable -> READ.
- READ:
  - o_rom_rd=1, o_rom_addr=ptr -> DECODE.
- DECODE (i_rom_data valid):
  - note/rest: latch note (0 if rest), duration and rest flag; ptr=ptr+1 (wraps 2^ADDR_WIDTH-1 -> 0); loop_seen=0 -> RESPOND.
  - loop with loop_seen=0: ptr=target; loop_seen=1 -> READ.
  - loop with loop_seen=1 (two consecutive loop words): treated as end.
  - end: o_done=1 -> DONE.
- RESPOND:
  - o_valid=1 for exactly one cycle -> IDLE.
  - Outputs are registered, so values are visible in the same cycle as o_valid.
- Latency, enable at cycle N:
  - note/rest: o_rom_rd at N+1, o_valid at N+3.
  - Each taken loop adds 2 cycles.
- DONE:
  - Each i_enable produces o_valid 1 cycle later with o_rest=1, o_note=0, o_duration=all-ones.
  - This keeps the controller from deadlocking.
  - o_done stays 1; ptr frozen.
- i_enable while o_busy=1: ignored, not queued.
- i_restart (any state):
  - ptr=0, loop_seen=0, o_done=0, state IDLE; any in-flight fetch abandoned with no o_valid.
  - o_note, o_duration and o_rest keep their last values.
  - If i_enable is also high the same cycle, go directly to READ with ptr=0.
  - Restart has priority over DECODE and RESPOND that cycle.
- Reset mid-fetch: immediate return to the reset state; no o_valid.
- o_rom_rd is never asserted outside READ; o_rom_addr may be don't-care when o_rom_rd=0.

Test Plan:
- ROM[0]={00,note 12,dur 4}, ROM[1]={01,x,dur 2}; enable at N -> o_rom_rd/addr 0 at N+1, o_valid at N+3 with note 12/dur 4/rest 0. Second enable -> o_valid with rest 1, note 0, dur 2.
- ROM[2]={10,target 0}; third enable -> reads addr 2, then addr 0. o_valid at N+5 with note 12; a fourth enable returns the rest record at addr 1.
- ROM[0]={11}; enable -> o_done=1, no o_valid. Next enable -> o_valid 1 cycle later with rest 1, dur 63; o_done stays 1.
- ROM[0]={10,target 1}, ROM[1]={10,target 0}; enable -> two reads, then o_done=1 with no hang.
- i_restart in the DECODE cycle -> no o_valid, ptr=0. Restart+enable in the same cycle -> read of addr 0 on the next cycle.
- Fill ROM with notes; 64 enables -> addr wraps 63 -> 0 with correct data. Enable pulses while busy -> no extra o_valid.
